booth2_code_emitter: RTL and testbench

//   Radix-4 Booth encoder, serial side. Accepts one WIDTH-bit multiplier B over a valid/ready handshake.

---
 rtl/booth2_pkg.sv | 38 +++
 rtl/booth2_group_encoder.sv | 19 +
 rtl/booth2_code_emitter.sv | 104 ++++++++++
 tb/tb_booth2_code_emitter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/booth2_pkg.sv
// Shared radix-4 Booth definitions: code constants, decoded flag bundle,
// emitter state encoding and the code -> flags decode function.
package booth2_pkg;

    localparam logic [2:0] BOOTH_ZERO0 = 3'b000;
    localparam logic [2:0] BOOTH_POS1A = 3'b001;
    localparam logic [2:0] BOOTH_POS1B = 3'b010;
    localparam logic [2:0] BOOTH_POS2  = 3'b011;
    localparam logic [2:0] BOOTH_NEG2  = 3'b100;
    localparam logic [2:0] BOOTH_NEG1A = 3'b101;
    localparam logic [2:0] BOOTH_NEG1B = 3'b110;
    localparam logic [2:0] BOOTH_ZERO1 = 3'b111;

    typedef struct packed {
        logic flag_2x;
        logic flag_s1;
        logic flag_s2;
    } booth2_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // |pp|=2A only for +2/-2; sign flags are both clear for the two zero codes.
    function automatic booth2_flags_t booth2_decode(input logic [2:0] c);
        booth2_flags_t f;
        f.flag_2x = (c == BOOTH_POS2) | (c == BOOTH_NEG2);
        f.flag_s1 = c[2] & ~(c[1] & c[0]);
        f.flag_s2 = ~c[2] & (c[1] | c[0]);
        return f;
    endfunction

    function automatic logic booth2_is_zero(input logic [2:0] c);
        return (c == BOOTH_ZERO0) || (c == BOOTH_ZERO1);
    endfunction

endpackage

// File: rtl/booth2_group_encoder.sv
// Combinational decode of one 3-bit radix-4 Booth code into its
// partial-product selection flags.
module booth2_group_encoder
    import booth2_pkg::*;
(
    input  logic [2:0] code,
    output logic       flag_2x,
    output logic       flag_s1,
    output logic       flag_s2
);

    booth2_flags_t flags;

    assign flags   = booth2_decode(code);
    assign flag_2x = flags.flag_2x;
    assign flag_s1 = flags.flag_s1;
    assign flag_s2 = flags.flag_s2;

endmodule

// File: rtl/booth2_code_emitter.sv
// Serial radix-4 Booth code emitter: accepts one multiplier operand and emits
// one Booth group per beat. Optional zero-group skipping: BOOTH2_ZERO_SKIP_EN.
module booth2_code_emitter
    import booth2_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int GROUPS = WIDTH / 2,
    localparam int IDX_W  = $clog2(GROUPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [2:0]       code_out,
    output logic [IDX_W-1:0] code_idx,
    output logic             flag_2x,
    output logic             flag_s1,
    output logic             flag_s2,
    output logic             code_last,
    output logic             code_valid,
    input  logic             code_ready
);

    state_t           state_q, state_d;
    logic [WIDTH:0]   sreg_q, sreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             is_last;
    logic             skip;

    assign is_last = (idx_q == IDX_W'(GROUPS - 1));

    // A skipped group never raises code_valid; the final group is never skipped
    // so every operand still delivers exactly one code_last.
`ifdef BOOTH2_ZERO_SKIP_EN
    assign skip = (state_q == EMIT) && !is_last && booth2_is_zero(sreg_q[2:0]);
`else
    assign skip = 1'b0;
`endif

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no
    // path through the case leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        b_ready    = 1'b0;
        code_valid = 1'b0;
        code_last  = 1'b0;
        code_out   = BOOTH_ZERO0;
        code_idx   = idx_q;

        unique case (state_q)
            IDLE: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    sreg_d  = {b_in, 1'b0};
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                code_out   = sreg_q[2:0];
                code_last  = is_last;
                code_valid = !skip;
                if (skip || code_ready) begin
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        // Arithmetic shift keeps the operand sign for the top group.
                        sreg_d = {{2{sreg_q[WIDTH]}}, sreg_q[WIDTH:2]};
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    booth2_group_encoder u_group_encoder (
        .code    (code_out),
        .flag_2x (flag_2x),
        .flag_s1 (flag_s1),
        .flag_s2 (flag_s2)
    );

endmodule

// File: tb/tb_booth2_code_emitter.sv
// Directed table-driven bench for booth2_code_emitter (WIDTH=16), plus
// hand-written backpressure and mid-stream reset sequences.
module tb_booth2_code_emitter;

    localparam int WIDTH  = 16;
    localparam int GROUPS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] b_in;
    logic        b_valid;
    logic        b_ready;
    logic [2:0]  code_out;
    logic [2:0]  code_idx;
    logic        flag_2x;
    logic        flag_s1;
    logic        flag_s2;
    logic        code_last;
    logic        code_valid;
    logic        code_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] b;
        logic [23:0] codes;      // group i at [3*i +: 3]
        int          stall_idx;  // -1: no backpressure
    } vec_t;

    vec_t vecs[7];

    booth2_code_emitter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .b_in       (b_in),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .code_out   (code_out),
        .code_idx   (code_idx),
        .flag_2x    (flag_2x),
        .flag_s1    (flag_s1),
        .flag_s2    (flag_s2),
        .code_last  (code_last),
        .code_valid (code_valid),
        .code_ready (code_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-written truth table {flag_2x, flag_s1, flag_s2}.
    function automatic logic [2:0] exp_flags(input logic [2:0] c);
        case (c)
            3'b000:  return 3'b000;
            3'b001:  return 3'b001;
            3'b010:  return 3'b001;
            3'b011:  return 3'b101;
            3'b100:  return 3'b110;
            3'b101:  return 3'b010;
            3'b110:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_beat(input int i, input logic [2:0] c);
        check($sformatf("code_valid[%0d]", i), code_valid, 1);
        check($sformatf("code_idx[%0d]", i), code_idx, i);
        check($sformatf("code_out[%0d]", i), code_out, c);
        check($sformatf("flags[%0d]", i), {flag_2x, flag_s1, flag_s2}, exp_flags(c));
        check($sformatf("code_last[%0d]", i), code_last, (i == GROUPS - 1));
        check($sformatf("b_ready_emit[%0d]", i), b_ready, 0);
    endtask

    task automatic run_vector(input vec_t v);
        logic [2:0] c;
        int budget;
        check("b_ready_idle", b_ready, 1);
        b_in    = v.b;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        b_in    = ~v.b;
        for (int i = 0; i < GROUPS; i++) begin
            c = v.codes[3*i +: 3];
`ifdef BOOTH2_ZERO_SKIP_EN
            if (i != GROUPS - 1 && (c == 3'b000 || c == 3'b111)) continue;
`endif
            budget = 0;
            while (!code_valid && budget < GROUPS + 2) begin
                @(posedge clk); #1;
                budget++;
            end
            if (!code_valid) begin
                check("beat_timeout", code_valid, 1);
                return;
            end
            check_beat(i, c);
            if (i == v.stall_idx) begin
                code_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    b_valid = 1'b1;
                    b_in    = 16'hFFFF;
                    @(posedge clk); #1;
                    check_beat(i, c);
                end
                b_valid    = 1'b0;
                code_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("bubble_code_valid", code_valid, 0);
        check("bubble_b_ready", b_ready, 1);
        check("bubble_code_idx", code_idx, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0000, {8{3'b000}}, -1};
        vecs[1] = '{16'h0001, {{7{3'b000}}, 3'b010}, -1};
        vecs[2] = '{16'hFFFF, {{7{3'b111}}, 3'b110}, -1};
        vecs[3] = '{16'h8000, {3'b100, {7{3'b000}}}, -1};
        vecs[4] = '{16'h5A5A, {3'b010, 3'b011, 3'b101, 3'b100,
                               3'b010, 3'b011, 3'b101, 3'b100}, 3};
        vecs[5] = '{16'h1234, {3'b000, 3'b010, 3'b001, 3'b100,
                               3'b001, 3'b110, 3'b010, 3'b000}, -1};
        vecs[6] = '{16'hAAAA, {{7{3'b101}}, 3'b100}, 5};

        rst        = 1'b1;
        b_in       = 16'h0000;
        b_valid    = 1'b0;
        code_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_b_ready", b_ready, 1);
        check("rst_code_valid", code_valid, 0);
        check("rst_code_last", code_last, 0);
        check("rst_code_idx", code_idx, 0);
        check("rst_code_out", code_out, 0);
        check("rst_flags", {flag_2x, flag_s1, flag_s2}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 7; n++) run_vector(vecs[n]);

        // Reset in the middle of an operand discards it.
        check("pre_rst_b_ready", b_ready, 1);
        b_in    = 16'h5A5A;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_idx", code_idx, 4);
        check("pre_rst_code_out", code_out, 3'b100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_code_valid", code_valid, 0);
        check("mid_rst_b_ready", b_ready, 1);
        check("mid_rst_code_idx", code_idx, 0);
        check("mid_rst_code_last", code_last, 0);
        run_vector(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
